// File: rtl/mips_pkg.sv
// Shared MIPS fetch-path constants, PC source encodings and fetch FSM states.
// Imported by every fetch-path file.
package mips_pkg;

  localparam logic [31:0] PC_RESET      = 32'h0000_0000;
  localparam logic [7:0]  FETCH_TIMEOUT = 8'd255;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_HOLD   = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] jump_target(
    input logic [31:0] pc,
    input logic [31:0] ir
  );
    return {pc[31:28], ir[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/address out, data/ready back.
// The fetch unit is the master.
interface fetch_unit_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection for the fetch unit.
// Jump targets are formed from the current (pre-load) ir.
module pc_next_mux
  import mips_pkg::*;
(
  input  logic [1:0]  pc_src,
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  output logic [31:0] pc_next
);

  always_comb begin
    pc_next = pc;
    unique case (pc_src)
      PC_SRC_ALU:    pc_next = alu_result;
      PC_SRC_ALUOUT: pc_next = alu_out;
      PC_SRC_JUMP:   pc_next = jump_target(pc, ir);
      PC_SRC_HOLD:   pc_next = pc;
      default:       pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle MIPS fetch unit: PC register, IR, and a two-state
// memory fetch FSM with a wait-cycle timeout that inserts a NOP.
module fetch_unit
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               ir_write,
  input  logic               pc_en,
  input  logic [1:0]         pc_src,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        alu_out,
  fetch_unit_if.master       mem,
  output logic [31:0]        pc,
  output logic [31:0]        ir,
  output logic [5:0]         op,
  output logic [5:0]         funct,
  output logic               busy,
  output logic               fetch_err
);

  fetch_state_e state;
  logic [31:0]  addr_q;
  logic         req_q;
  logic [7:0]   wait_cnt;
  logic [7:0]   wait_nxt;
  logic [31:0]  pc_next;

  pc_next_mux u_pc_mux (
    .pc_src     (pc_src),
    .pc         (pc),
    .ir         (ir),
    .alu_result (alu_result),
    .alu_out    (alu_out),
    .pc_next    (pc_next)
  );

  assign wait_nxt      = wait_cnt + 8'd1;
  assign mem.mem_req   = req_q;
  assign mem.mem_addr  = addr_q;
  assign op            = ir[31:26];
  assign funct         = ir[5:0];
  assign busy          = (state == ST_FETCH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= PC_RESET;
    end else if (pc_en) begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      addr_q    <= PC_RESET;
      req_q     <= 1'b0;
      wait_cnt  <= 8'd0;
      ir        <= 32'h0;
      fetch_err <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ir_write) begin
            addr_q   <= pc;
            req_q    <= 1'b1;
            wait_cnt <= 8'd0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (mem.mem_ready) begin
            ir    <= mem.mem_rdata;
            req_q <= 1'b0;
            state <= ST_IDLE;
          end else if (wait_nxt == FETCH_TIMEOUT) begin
            // give up: retire a NOP so the control unit can move on
            wait_cnt  <= wait_nxt;
            ir        <= 32'h0;
            fetch_err <= 1'b1;
            req_q     <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit.
// Hand-computed expectations, one checking task.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        ir_write;
  logic        pc_en;
  logic [1:0]  pc_src;
  logic [31:0] alu_result;
  logic [31:0] alu_out;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        busy;
  logic        fetch_err;

  int n_vec;
  int n_err;
  int req_rises;
  logic req_d;

  fetch_unit_if mem ();

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .alu_result (alu_result),
    .alu_out    (alu_out),
    .mem        (mem),
    .pc         (pc),
    .ir         (ir),
    .op         (op),
    .funct      (funct),
    .busy       (busy),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem.mem_req && !req_d) req_rises <= req_rises + 1;
    req_d <= mem.mem_req;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_en      = 1'b1;
    pc_src     = 2'b00;
    alu_result = v;
    tick();
    pc_en      = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] data);
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    mem.mem_ready = 1'b1;
    mem.mem_rdata = data;
    tick();
    mem.mem_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    req_rises = 0;
    req_d = 1'b0;
    reset = 1'b0;
    ir_write = 1'b0;
    pc_en = 1'b0;
    pc_src = 2'b00;
    alu_result = 32'h0;
    alu_out = 32'h0;
    mem.mem_ready = 1'b0;
    mem.mem_rdata = 32'h0;
    tick();
    tick();
    reset = 1'b1;

    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_req", {31'h0, mem.mem_req}, 32'h0);
    chk("rst_err", {31'h0, fetch_err}, 32'h0);

    // basic fetch with 3 wait cycles
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    chk("f1_busy", {31'h0, busy}, 32'h1);
    chk("f1_req", {31'h0, mem.mem_req}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("f1_addr", mem.mem_addr, 32'h0);
      tick();
    end
    chk("f1_ir_wait", ir, 32'h0);
    chk("f1_busy_wait", {31'h0, busy}, 32'h1);
    mem.mem_ready = 1'b1;
    mem.mem_rdata = 32'h012A_4020;
    tick();
    mem.mem_ready = 1'b0;
    chk("f1_ir", ir, 32'h012A_4020);
    chk("f1_op", {26'h0, op}, 32'h0);
    chk("f1_funct", {26'h0, funct}, 32'h20);
    chk("f1_busy_done", {31'h0, busy}, 32'h0);
    chk("f1_req_done", {31'h0, mem.mem_req}, 32'h0);

    // jump target uses pc[31:28] and ir[25:0]
    set_pc(32'h0000_0100);
    fetch(32'h0800_0040);
    chk("j_ir", ir, 32'h0800_0040);
    chk("j_op", {26'h0, op}, 32'h2);
    pc_en = 1'b1;
    pc_src = 2'b10;
    tick();
    pc_en = 1'b0;
    chk("j_pc", pc, 32'h0000_0100);

    set_pc(32'hA000_0000);
    pc_en = 1'b1;
    pc_src = 2'b10;
    tick();
    pc_en = 1'b0;
    chk("j_hi", pc, 32'hA000_0100);

    // jump on the same edge as an IR load sees the old IR
    set_pc(32'h0000_0000);
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    mem.mem_ready = 1'b1;
    mem.mem_rdata = 32'h0800_0080;
    pc_en = 1'b1;
    pc_src = 2'b10;
    tick();
    mem.mem_ready = 1'b0;
    pc_en = 1'b0;
    chk("j_old_pc", pc, 32'h0000_0100);
    chk("j_new_ir", ir, 32'h0800_0080);
    pc_en = 1'b1;
    tick();
    pc_en = 1'b0;
    chk("j_new_pc", pc, 32'h0000_0200);

    // alu_out path, hold encoding, pc_en low
    pc_en = 1'b1;
    pc_src = 2'b01;
    alu_out = 32'h0000_0444;
    tick();
    chk("src01", pc, 32'h0000_0444);
    pc_src = 2'b11;
    alu_result = 32'h5555_5555;
    tick();
    chk("src11", pc, 32'h0000_0444);
    pc_en = 1'b0;
    pc_src = 2'b00;
    tick();
    chk("pc_en0", pc, 32'h0000_0444);
    set_pc(32'hFFFF_FFFC);
    chk("pc_wrap_in", pc, 32'hFFFF_FFFC);

    // PC moves during fetch, address stays latched
    set_pc(32'h0000_0008);
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    pc_en = 1'b1;
    alu_result = 32'h0000_000C;
    tick();
    pc_en = 1'b0;
    chk("mv_pc", pc, 32'h0000_000C);
    chk("mv_addr0", mem.mem_addr, 32'h0000_0008);
    tick();
    chk("mv_addr1", mem.mem_addr, 32'h0000_0008);
    mem.mem_ready = 1'b1;
    mem.mem_rdata = 32'h1234_5678;
    tick();
    mem.mem_ready = 1'b0;
    chk("mv_ir", ir, 32'h1234_5678);

    // ir_write during FETCH ignored; mem_ready in IDLE ignored
    req_rises = 0;
    ir_write = 1'b1;
    tick();
    tick();
    ir_write = 1'b0;
    tick();
    mem.mem_ready = 1'b1;
    mem.mem_rdata = 32'h0000_BEEF;
    tick();
    mem.mem_ready = 1'b0;
    chk("q_ir", ir, 32'h0000_BEEF);
    chk("q_busy", {31'h0, busy}, 32'h0);
    tick();
    chk("q_req", {31'h0, mem.mem_req}, 32'h0);
    mem.mem_ready = 1'b1;
    mem.mem_rdata = 32'hDEAD_DEAD;
    tick();
    mem.mem_ready = 1'b0;
    chk("idle_rdy_ir", ir, 32'h0000_BEEF);
    chk("q_rises", req_rises, 32'd1);

    // timeout after 255 FETCH cycles
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    chk("to_busy254", {31'h0, busy}, 32'h1);
    chk("to_err254", {31'h0, fetch_err}, 32'h0);
    tick();
    chk("to_busy", {31'h0, busy}, 32'h0);
    chk("to_err", {31'h0, fetch_err}, 32'h1);
    chk("to_ir", ir, 32'h0);
    chk("to_req", {31'h0, mem.mem_req}, 32'h0);
    fetch(32'h0000_0F0F);
    chk("to_sticky", {31'h0, fetch_err}, 32'h1);
    chk("to_ir2", ir, 32'h0000_0F0F);

    // reset mid-fetch, late mem_ready
    set_pc(32'h0000_0020);
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    chk("rf_addr", mem.mem_addr, 32'h0000_0020);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mem.mem_ready = 1'b1;
    mem.mem_rdata = 32'hCAFE_F00D;
    tick();
    mem.mem_ready = 1'b0;
    chk("rf_req", {31'h0, mem.mem_req}, 32'h0);
    chk("rf_ir", ir, 32'h0);
    chk("rf_pc", pc, 32'h0);
    chk("rf_err", {31'h0, fetch_err}, 32'h0);
    chk("rf_busy", {31'h0, busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
